// File: rtl/axis_cpu_fetch.sv
// Fetch stage: issues PC reads to a 1-cycle synchronous imem and buffers returns in a 2-entry FIFO.
// First vld two cycles after reset release, then 1 instr/cycle; credit-gated issue stalls while decode holds next_rdy low.
module axis_cpu_fetch #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 8,
  parameter int COUNT_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_rd_en,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   branch_mispredict,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   PC_en,
  output logic [COUNT_WIDTH-1:0] ocount,
  output logic                   vld,
  input  logic                   next_rdy
);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
    logic [COUNT_WIDTH-1:0] ocount;
  } entry_t;

  entry_t [1:0]          fifo_q, fifo_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   tag_q, tag_d;

  logic                  pop;
  logic                  push;
  logic [1:0]            used;

  assign vld       = (count_q != 2'd0);
  assign instr_out = fifo_q[0].instr;
  assign pc_out    = fifo_q[0].pc;
  assign ocount    = fifo_q[0].ocount;
  assign imem_addr = pc_q;
  assign PC_en     = imem_rd_en;

  assign pop  = vld && next_rdy;
  // An in-flight read always has a reserved slot, so a return can be pushed unconditionally.
  assign used = count_q + {1'b0, inflight_q} - {1'b0, pop};
  assign imem_rd_en = rst_n && !branch_mispredict && (used < 2'd2);
  assign push = inflight_q && !branch_mispredict;

  always_comb begin
    fifo_d  = fifo_q;
    count_d = count_q;
    pc_d    = pc_q;
    tag_d   = tag_q;

    if (PC_en) begin
      for (int i = 0; i < 2; i++) begin
        if (fifo_d[i].ocount != {COUNT_WIDTH{1'b1}})
          fifo_d[i].ocount = fifo_d[i].ocount + COUNT_WIDTH'(1);
      end
    end

    if (branch_mispredict) begin
      count_d = 2'd0;
      pc_d    = branch_target;
    end else begin
      if (pop) begin
        fifo_d[0] = fifo_d[1];
        count_d   = count_d - 2'd1;
      end
      if (push) begin
        fifo_d[count_d[0]].instr  = imem_rdata;
        fifo_d[count_d[0]].pc     = tag_q;
        fifo_d[count_d[0]].ocount = '0;
        count_d = count_d + 2'd1;
      end
      if (imem_rd_en) begin
        pc_d  = pc_q + PC_WIDTH'(1);
        tag_d = pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q     <= '0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      pc_q       <= '0;
      tag_q      <= '0;
    end else begin
      fifo_q     <= fifo_d;
      count_q    <= count_d;
      inflight_q <= imem_rd_en;
      pc_q       <= pc_d;
      tag_q      <= tag_d;
    end
  end

endmodule
